// File: rtl/kbd_event_fifo.sv
// Captures keyboard/mouse words from a ready/retrieved upstream handshake into a FWFT FIFO.
// A word is written the cycle after it is sampled; a full FIFO holds the word off upstream and flags overrun.
module kbd_event_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          kb_data_ready,
  input  logic          kb_is_mouse,
  input  logic [15:0]   kb_data,
  output logic          kb_data_retrieved,
  input  logic          mouse_enable,
  output logic          out_valid,
  output logic [15:0]   out_data,
  output logic          out_is_mouse,
  input  logic          out_ready,
  output logic [AW:0]   fifo_count,
  output logic          irq,
  output logic          overrun,
  input  logic          overrun_clr
);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = 1;

  state_t        state, state_nxt;
  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, take, push, pop, ovr_evt;

  // Full is judged on the pre-pop count, so a simultaneous pop never lets a held-off word in.
  assign full = (fifo_count == CNT_FULL);
  assign pop  = out_valid & out_ready;
  assign push = take & ~(kb_is_mouse & ~mouse_enable);

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    ovr_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (kb_data_ready) begin
          if (full) begin
            ovr_evt = 1'b1;
          end else begin
            take      = 1'b1;
            state_nxt = ACK;
          end
        end
      end
      ACK:      state_nxt = WAIT_LOW;
      WAIT_LOW: if (!kb_data_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_count        <= '0;
      kb_data_retrieved <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      state             <= state_nxt;
      kb_data_retrieved <= take;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
      overrun <= ovr_evt | (overrun & ~overrun_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= {kb_is_mouse, kb_data};
  end

  assign out_valid                = (fifo_count != '0);
  assign irq                      = out_valid;
  assign {out_is_mouse, out_data} = mem[rd_ptr];

endmodule

// File: doc/kbd_event_fifo.md
KBD_EVENT_FIFO -- requirements
Module: kbd_event_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of FIFO entries; SHALL be a power of two, range 2..64.
REQ-002 Parameter AW, default 3, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  monitor clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 kb_data_ready  input  1  upstream keyboard receiver has a word pending.
REQ-006 kb_is_mouse  input  1  pending word is mouse data (0 = keyboard).
REQ-007 kb_data  input  16  pending keyboard/mouse word.
REQ-008 kb_data_retrieved  output  1  one-cycle pulse acknowledging the pending word to upstream.
REQ-009 mouse_enable  input  1  0 = mouse words are acknowledged but discarded.
REQ-010 out_valid  output  1  FIFO head holds a valid entry.
REQ-011 out_data  output  16  head entry data.
REQ-012 out_is_mouse  output  1  head entry type.
REQ-013 out_ready  input  1  consumer accepts head this cycle.
REQ-014 fifo_count  output  AW+1  number of stored entries, 0..DEPTH.
REQ-015 irq  output  1  level interrupt, high while fifo_count != 0.
REQ-016 overrun  output  1  sticky: a word was held off because the FIFO was full.
REQ-017 overrun_clr  input  1  clears overrun.

Function
REQ-018 Capture FSM SHALL have states IDLE, ACK, WAIT_LOW.
REQ-019 IDLE: kb_data_ready=1 and FIFO not full -> write {kb_is_mouse, kb_data} (skipped if kb_is_mouse=1 and mouse_enable=0), kb_data_retrieved<=1, go ACK.
REQ-020 IDLE: kb_data_ready=1 and FIFO full -> no write, no ack, overrun<=1, stay IDLE; word remains pending upstream.
REQ-021 ACK: kb_data_retrieved<=0, go WAIT_LOW; kb_data_retrieved SHALL be high for exactly one cycle per accepted word.
REQ-022 WAIT_LOW: stay until kb_data_ready=0, then go IDLE; a word SHALL never be captured twice.
REQ-023 Capture latency: write visible at out_valid/fifo_count the cycle after the IDLE-state sample.
REQ-024 Pop occurs when out_valid=1 and out_ready=1; out_ready with out_valid=0 SHALL be ignored.
REQ-025 Push and pop in the same cycle: both performed, fifo_count unchanged; allowed when full (pop frees slot) only if the push decision saw not-full, i.e. full-check uses pre-pop count.
REQ-026 out_data/out_is_mouse SHALL be driven from the entry at the read pointer (first-word-fall-through); undefined contents permitted when out_valid=0 but SHALL not change out_valid.
REQ-027 Read/write pointers AW bits, wrap modulo DEPTH; full = fifo_count==DEPTH, empty = fifo_count==0.
REQ-028 Entries SHALL be delivered in capture order; no reordering between keyboard and mouse words.
REQ-029 overrun_clr and a new overrun event in the same cycle: overrun SHALL be 1.
REQ-030 irq SHALL equal out_valid registered-equivalently (no combinational path from inputs).

Reset
REQ-031 With reset=1 at a rising edge: FSM<=IDLE, pointers<=0, fifo_count<=0, out_valid<=0, irq<=0, kb_data_retrieved<=0, overrun<=0.
REQ-032 Reset mid-operation SHALL discard all stored entries; a word pending upstream during reset SHALL be captured after reset deasserts.
REQ-033 Reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-034 kb_data_ready=1, kb_is_mouse=0, kb_data=16'h0A3C, empty FIFO -> one-cycle kb_data_retrieved, next cycle out_valid=1, out_data=16'h0A3C, fifo_count=1, irq=1.
REQ-035 Fill 8 words 16'h0001..16'h0008, 9th word pending -> no ack, overrun=1; pop one -> 9th captured; pops return 0002..0009 in order.
REQ-036 mouse_enable=0, mouse word 16'h0102 -> ack pulse, fifo_count stays 0, out_valid=0.
REQ-037 kb_data_ready held high for 20 cycles after ack (slow upstream) -> exactly one entry stored.
REQ-038 Full FIFO with out_ready=1 and new word pending same cycle -> pop performed, word captured next IDLE sample, fifo_count returns to 8.
REQ-039 Reset asserted with 3 entries stored -> next cycle fifo_count=0, out_valid=0, irq=0, overrun=0.
